// File: rtl/sample_scheduler.sv
// Periodic ADC sample scheduler: tick divider, IDLE/BUSY conversion FSM with
// timeout, and a first-word-fall-through result FIFO with sticky status flags.
module sample_scheduler #(
    parameter int unsigned DIV     = 2500,
    parameter int unsigned TIMEOUT = 2048,
    parameter int unsigned AW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic          start_sample,
    input  logic          sample_done,
    input  logic [9:0]    sample,
    output logic [9:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   fifo_count,
    input  logic          clr_flags,
    output logic          overrun,
    output logic          missed_tick,
    output logic          timeout_err
);

    localparam int unsigned DW    = 10;
    localparam int unsigned TW    = 16;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned WW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [TW-1:0] tick_cnt;
    logic          tick_c;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    logic          start_nxt;
    logic          push_c;
    logic          set_timeout_c;
    logic          set_missed_c;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic [CW-1:0] count_nxt;
    logic [DW-1:0] head_nxt;
    logic          full_c;
    logic          pop_c;
    logic          wr_en_c;
    logic          set_overrun_c;

    assign tick_c = enable && (tick_cnt == TW'(DIV - 1));

    // Free-running sample-rate divider, parked at zero while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (!enable || tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Conversion FSM next-state and event decode
    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        start_nxt     = 1'b0;
        push_c        = 1'b0;
        set_timeout_c = 1'b0;
        set_missed_c  = 1'b0;
        case (state)
            IDLE: begin
                wait_nxt = '0;
                if (tick_c) begin
                    state_nxt = BUSY;
                    start_nxt = 1'b1;
                end
            end
            BUSY: begin
                // A tick here cannot start a conversion; it is only recorded
                set_missed_c = tick_c;
                if (sample_done) begin
                    push_c    = 1'b1;
                    state_nxt = IDLE;
                    wait_nxt  = '0;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    set_timeout_c = 1'b1;
                    state_nxt     = IDLE;
                    wait_nxt      = '0;
                end else begin
                    wait_nxt = wait_cnt + WW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                wait_nxt  = '0;
            end
        endcase
    end

    // FSM state, wait counter and registered start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            start_sample <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_nxt;
            start_sample <= start_nxt;
        end
    end

    assign full_c        = (fifo_count == CW'(DEPTH));
    assign pop_c         = out_valid && out_ready;
    assign wr_en_c       = push_c && (!full_c || pop_c);
    assign set_overrun_c = push_c && full_c && !pop_c;
    assign count_nxt     = fifo_count + CW'(wr_en_c) - CW'(pop_c);
    assign rd_nxt        = rd_ptr + AW'(pop_c);

    // Next head word; bypasses the array when the head slot is written this cycle
    always_comb begin
        head_nxt = '0;
        if (count_nxt != '0) begin
            if (wr_en_c && (wr_ptr == rd_nxt)) begin
                head_nxt = sample;
            end else begin
                head_nxt = mem[rd_nxt];
            end
        end
    end

    // Storage array, no reset needed since reads are qualified by occupancy
    always_ff @(posedge clk) begin
        if (!rst && wr_en_c) begin
            mem[wr_ptr] <= sample;
        end
    end

    // FIFO pointers, occupancy and registered head/valid
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_nxt;
            fifo_count <= count_nxt;
            out_valid  <= (count_nxt != '0);
            out_data   <= head_nxt;
        end
    end

    // Sticky flags; a same-cycle set takes priority over clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun     <= 1'b0;
            missed_tick <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overrun     <= set_overrun_c || (overrun && !clr_flags);
            missed_tick <= set_missed_c  || (missed_tick && !clr_flags);
            timeout_err <= set_timeout_c || (timeout_err && !clr_flags);
        end
    end

endmodule

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 SHALL have parameter DIV, default 2500, meaning clk cycles between sample ticks (40 kHz at 100 MHz); legal range 16..65535.
REQ-002 SHALL have parameter TIMEOUT, default 2048, meaning max clk cycles to wait for sample_done after start_sample.
REQ-003 SHALL have parameter AW, default 4, meaning FIFO address width (depth 2^AW = 16).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable  input  1  level; 1 = periodic sampling runs.
REQ-007 SHALL have port start_sample  output  1  one-cycle pulse to the ADC sampler.
REQ-008 SHALL have port sample_done  input  1  one-cycle pulse from the ADC sampler; sample valid in the same cycle.
REQ-009 SHALL have port sample  input  10  ADC result.
REQ-010 SHALL have port out_data  output  10  FIFO head word.
REQ-011 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head when out_valid=1.
REQ-013 SHALL have port fifo_count  output  AW+1  current FIFO occupancy, 0..2^AW.
REQ-014 SHALL have port clr_flags  input  1  one-cycle pulse clearing sticky flags.
REQ-015 SHALL have port overrun  output  1  sticky: a sample was dropped because the FIFO was full.
REQ-016 SHALL have port missed_tick  output  1  sticky: a tick occurred while a conversion was in flight.
REQ-017 SHALL have port timeout_err  output  1  sticky: sample_done did not arrive within TIMEOUT cycles.

Function
REQ-018 Tick counter SHALL count 0..DIV-1 while enable=1 and wrap to 0; tick = 1 in the cycle count==DIV-1; counter held at 0 while enable=0.
REQ-019 FSM states SHALL be IDLE and BUSY only.
REQ-020 IDLE: on tick, SHALL assert start_sample for exactly one cycle (registered, the cycle after tick) and enter BUSY.
REQ-021 BUSY: on sample_done, SHALL push sample into the FIFO and return to IDLE in the next cycle.
REQ-022 BUSY: wait counter SHALL start at 0 on entry; when it reaches TIMEOUT-1 without sample_done, SHALL set timeout_err and return to IDLE; no FIFO push.
REQ-023 Tick while in BUSY SHALL be dropped and SHALL set missed_tick; no start_sample issued.
REQ-024 sample_done while in IDLE SHALL be ignored (no push, no flag).
REQ-025 enable falling during BUSY SHALL NOT abort the conversion; the result is still pushed; no new start_sample issues until enable=1 and a new tick.
REQ-026 FIFO SHALL be first-word-fall-through: out_data = oldest entry whenever out_valid=1; pop occurs when out_valid && out_ready.
REQ-027 A push SHALL be accepted if fifo_count < 2^AW, or if a pop occurs in the same cycle (full + push + pop: count unchanged, data order preserved).
REQ-028 A push to a full FIFO with no simultaneous pop SHALL drop the sample and set overrun.
REQ-029 Simultaneous push and pop on an empty FIFO SHALL not pop (out_valid=0); the push is accepted and count becomes 1.
REQ-030 Read/write pointers SHALL be AW bits and wrap modulo 2^AW.
REQ-031 clr_flags SHALL clear all sticky flags the next cycle; if a flag-setting event occurs in the same cycle, set wins.

Reset
REQ-032 On rst=1 at posedge clk: start_sample=0, out_valid=0, fifo_count=0, out_data=0, overrun=0, missed_tick=0, timeout_err=0, FSM=IDLE, tick and wait counters=0, pointers=0.
REQ-033 rst mid-conversion SHALL abandon the conversion; a later sample_done SHALL be ignored (FSM in IDLE).

Verification
REQ-034 DIV=16, enable=1, sampler model answers 20 cycles after start_sample with values 1,2,3: start_sample pulses every 16 cycles... (except as REQ-023 dictates); with 10-cycle response, FIFO reads 1,2,3 in order, no flags.
REQ-035 out_ready=0, 17 conversions completed: fifo_count=16, overrun=1, out_data = first sample; the 17th value is absent.
REQ-036 FIFO full, out_ready=1 in the cycle sample_done arrives: count stays 16, new sample appended at tail, overrun=0.
REQ-037 DIV=16, sampler response 20 cycles: missed_tick=1 after the second tick; clr_flags pulse -> missed_tick=0 the next cycle unless another miss occurs in that same cycle.
REQ-038 Sampler never responds, TIMEOUT=32: timeout_err=1 exactly 32 cycles after entering BUSY, FSM back in IDLE, next tick issues start_sample.
REQ-039 rst asserted 5 cycles into BUSY, sample_done injected 3 cycles after rst release: all outputs at reset values, fifo_count=0.
